// File: rtl/dpram_port_arbiter_pkg.sv
// Shared constants and helpers for the dual-port RAM port arbiter.
// Data/byte-enable widths match the buffer RAM; onehot2bin encodes a grant vector.
package dpram_port_arbiter_pkg;

  localparam int DPRAM_DW  = 32;
  localparam int DPRAM_BW  = 4;
  localparam int MAX_PORTS = 8;

  function automatic logic [2:0] onehot2bin(input logic [MAX_PORTS-1:0] oh);
    logic [2:0] bin;
    bin = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (oh[i]) bin = bin | 3'(i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/dpram_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester strictly after
// rr_ptr_i, wrapping, returned one-hot with a valid flag.
module dpram_rr_pick
  import dpram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = 1
) (
  input  logic [NUM_PORTS-1:0] eligible_i,
  input  logic [PTR_W-1:0]     rr_ptr_i,
  output logic [NUM_PORTS-1:0] winner_o,
  output logic                 valid_o
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    // Search order starts one past the last winner so it gets lowest priority.
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = PTR_W'((int'(rr_ptr_i) + k) % NUM_PORTS);
      if (!valid_o && eligible_i[idx]) begin
        winner_o[idx] = 1'b1;
        valid_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one byte-writable RAM port between NUM_PORTS requesters.
// Arbitrate at t, drive the RAM at t+1, ack with registered read data at t+2.
module dpram_port_arbiter
  import dpram_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_PORTS-1:0]             req_i,
  input  logic [DPRAM_BW*NUM_PORTS-1:0]    we_i,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0]  addr_i,
  input  logic [DPRAM_DW*NUM_PORTS-1:0]    dat_i,
  output logic [NUM_PORTS-1:0]             ack_o,
  output logic [DPRAM_DW-1:0]              dat_o,
  output logic [NUM_PORTS-1:0]             grant_o,
  output logic [ADDR_WIDTH-1:0]            ram_addr_o,
  output logic [DPRAM_BW-1:0]              ram_we_o,
  output logic [DPRAM_DW-1:0]              ram_di_o,
  input  logic [DPRAM_DW-1:0]              ram_do_i
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NUM_PORTS-1:0] eligible;
  logic [NUM_PORTS-1:0] winner;
  logic                 win_valid;
  logic [MAX_PORTS-1:0] winner_pad;

  logic [DPRAM_BW-1:0]   we_arr   [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] addr_arr [NUM_PORTS];
  logic [DPRAM_DW-1:0]   dat_arr  [NUM_PORTS];

  for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_unpack
    assign we_arr[gi]   = we_i[gi*DPRAM_BW +: DPRAM_BW];
    assign addr_arr[gi] = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign dat_arr[gi]  = dat_i[gi*DPRAM_DW +: DPRAM_DW];
  end

  // A port already granted or being acked must not win again on its held request.
  assign eligible = req_i & ~grant_q & ~ack_q;

  dpram_rr_pick #(
    .NUM_PORTS (NUM_PORTS),
    .PTR_W     (PTR_W)
  ) u_pick (
    .eligible_i (eligible),
    .rr_ptr_i   (rr_ptr_q),
    .winner_o   (winner),
    .valid_o    (win_valid)
  );

  always_comb begin
    winner_pad                = '0;
    winner_pad[NUM_PORTS-1:0] = winner;
    grant_d                   = win_valid ? winner : '0;
    rr_ptr_d                  = win_valid ? PTR_W'(onehot2bin(winner_pad)) : rr_ptr_q;
    ack_d                     = grant_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= '0;
      ack_q    <= '0;
      rr_ptr_q <= PTR_W'(NUM_PORTS - 1);
    end else begin
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // grant_q is one-hot or zero, so OR-ing gated fields is a mux that idles at zero.
  always_comb begin
    ram_we_o   = '0;
    ram_addr_o = '0;
    ram_di_o   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_q[i]) begin
        ram_we_o   = ram_we_o   | we_arr[i];
        ram_addr_o = ram_addr_o | addr_arr[i];
        ram_di_o   = ram_di_o   | dat_arr[i];
      end
    end
  end

  assign ack_o   = ack_q;
  assign grant_o = grant_q;
  assign dat_o   = ram_do_i;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Directed bench for dpram_port_arbiter with a behavioural read-before-write RAM
// on the shared port; cycle table plus hand sequences for reset and double service.
module tb_dpram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [3:0]  we0, we1;
  logic [2:0]  a0, a1;
  logic [31:0] d0, d1;
  logic [1:0]  ack_o, grant_o;
  logic [31:0] dat_o;
  logic [2:0]  ram_addr;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic [31:0] ram_do;
  logic [31:0] mem [8];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpram_port_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req),
    .we_i       ({we1, we0}),
    .addr_i     ({a1, a0}),
    .dat_i      ({d1, d0}),
    .ack_o      (ack_o),
    .dat_o      (dat_o),
    .grant_o    (grant_o),
    .ram_addr_o (ram_addr),
    .ram_we_o   (ram_we),
    .ram_di_o   (ram_di),
    .ram_do_i   (ram_do)
  );

  // Buffer RAM model: registered read of old contents, byte-lane writes.
  always @(posedge clk) begin
    ram_do <= mem[ram_addr];
    for (int b = 0; b < 4; b++)
      if (ram_we[b]) mem[ram_addr][b*8 +: 8] <= ram_di[b*8 +: 8];
  end

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  we0; logic [2:0] a0; logic [31:0] d0;
    logic [3:0]  we1; logic [2:0] a1; logic [31:0] d1;
    logic [1:0]  g;   logic [1:0] ack;
    logic [3:0]  rwe; logic [2:0] raddr; logic [31:0] rdi;
    logic        dchk; logic [31:0] dat;
  } vec_t;

  vec_t tv [22];

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req = v.req;
    we0 = v.we0; a0 = v.a0; d0 = v.d0;
    we1 = v.we1; a1 = v.a1; d1 = v.d1;
  endtask

  initial begin
    int wcount, acount, lat;
    bit acked;

    for (int i = 0; i < 8; i++) mem[i] = '0;

    //          req    we0   a0    d0            we1   a1    d1            g      ack    rwe   raddr rdi           dchk  dat
    tv[0]  = '{2'b11, 4'hF, 3'd1, 32'hA0A0A0A0, 4'hF, 3'd2, 32'hB1B1B1B1, 2'b01, 2'b00, 4'hF, 3'd1, 32'hA0A0A0A0, 1'b0, 32'h0};
    tv[1]  = '{2'b11, 4'hF, 3'd1, 32'hA0A0A0A0, 4'hF, 3'd2, 32'hB1B1B1B1, 2'b10, 2'b01, 4'hF, 3'd2, 32'hB1B1B1B1, 1'b1, 32'h0};
    tv[2]  = '{2'b11, 4'h0, 3'd2, 32'h0,        4'hF, 3'd2, 32'hB1B1B1B1, 2'b00, 2'b10, 4'h0, 3'd0, 32'h0,        1'b1, 32'h0};
    tv[3]  = '{2'b11, 4'h0, 3'd2, 32'h0,        4'h0, 3'd1, 32'h0,        2'b01, 2'b00, 4'h0, 3'd2, 32'h0,        1'b0, 32'h0};
    tv[4]  = '{2'b11, 4'h0, 3'd2, 32'h0,        4'h0, 3'd1, 32'h0,        2'b10, 2'b01, 4'h0, 3'd1, 32'h0,        1'b1, 32'hB1B1B1B1};
    tv[5]  = '{2'b10, 4'h0, 3'd0, 32'h0,        4'h0, 3'd1, 32'h0,        2'b00, 2'b10, 4'h0, 3'd0, 32'h0,        1'b1, 32'hA0A0A0A0};
    tv[6]  = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};
    tv[7]  = '{2'b01, 4'hF, 3'd3, 32'hDEADBEEF, 4'h0, 3'd0, 32'h0,        2'b01, 2'b00, 4'hF, 3'd3, 32'hDEADBEEF, 1'b0, 32'h0};
    tv[8]  = '{2'b01, 4'hF, 3'd3, 32'hDEADBEEF, 4'h0, 3'd0, 32'h0,        2'b00, 2'b01, 4'h0, 3'd0, 32'h0,        1'b1, 32'h0};
    tv[9]  = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};
    tv[10] = '{2'b01, 4'h0, 3'd3, 32'h0,        4'h0, 3'd0, 32'h0,        2'b01, 2'b00, 4'h0, 3'd3, 32'h0,        1'b0, 32'h0};
    tv[11] = '{2'b01, 4'h0, 3'd3, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b01, 4'h0, 3'd0, 32'h0,        1'b1, 32'hDEADBEEF};
    tv[12] = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};
    tv[13] = '{2'b01, 4'hF, 3'd5, 32'h11223344, 4'h0, 3'd0, 32'h0,        2'b01, 2'b00, 4'hF, 3'd5, 32'h11223344, 1'b0, 32'h0};
    tv[14] = '{2'b01, 4'hF, 3'd5, 32'h11223344, 4'h0, 3'd0, 32'h0,        2'b00, 2'b01, 4'h0, 3'd0, 32'h0,        1'b1, 32'h0};
    tv[15] = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};
    tv[16] = '{2'b01, 4'h2, 3'd5, 32'h0000AA00, 4'h0, 3'd0, 32'h0,        2'b01, 2'b00, 4'h2, 3'd5, 32'h0000AA00, 1'b0, 32'h0};
    tv[17] = '{2'b01, 4'h2, 3'd5, 32'h0000AA00, 4'h0, 3'd0, 32'h0,        2'b00, 2'b01, 4'h0, 3'd0, 32'h0,        1'b1, 32'h11223344};
    tv[18] = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};
    tv[19] = '{2'b01, 4'h0, 3'd5, 32'h0,        4'h0, 3'd0, 32'h0,        2'b01, 2'b00, 4'h0, 3'd5, 32'h0,        1'b0, 32'h0};
    tv[20] = '{2'b01, 4'h0, 3'd5, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b01, 4'h0, 3'd0, 32'h0,        1'b1, 32'h1122AA44};
    tv[21] = '{2'b00, 4'h0, 3'd0, 32'h0,        4'h0, 3'd0, 32'h0,        2'b00, 2'b00, 4'h0, 3'd0, 32'h0,        1'b0, 32'h0};

    // Reset held with every port requesting: nothing may be granted or written.
    drive(tv[0]);
    rst_n = 1'b0;
    repeat (3) cyc();
    chk("rst_ack",   32'(ack_o),    32'h0);
    chk("rst_grant", 32'(grant_o),  32'h0);
    chk("rst_we",    32'(ram_we),   32'h0);
    chk("rst_addr",  32'(ram_addr), 32'h0);
    chk("rst_di",    ram_di,        32'h0);
    $display("reset: ack=%b grant=%b we=%h", ack_o, grant_o, ram_we);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tv[i]);
      cyc();
      chk($sformatf("row%0d_grant", i), 32'(grant_o),  32'(tv[i].g));
      chk($sformatf("row%0d_ack", i),   32'(ack_o),    32'(tv[i].ack));
      chk($sformatf("row%0d_we", i),    32'(ram_we),   32'(tv[i].rwe));
      chk($sformatf("row%0d_addr", i),  32'(ram_addr), 32'(tv[i].raddr));
      chk($sformatf("row%0d_di", i),    ram_di,        tv[i].rdi);
      if (tv[i].dchk) chk($sformatf("row%0d_dat", i), dat_o, tv[i].dat);
      $display("row %0d: req=%b grant=%b ack=%b we=%h addr=%0d di=%h dat=%h",
               i, req, grant_o, ack_o, ram_we, ram_addr, ram_di, dat_o);
    end

    // Port 1 holds its write until ack then drops: exactly one RAM write.
    wcount = 0; acount = 0; lat = 0; acked = 1'b0;
    req = 2'b10; we1 = 4'hF; a1 = 3'd6; d1 = 32'h5A5A5A5A;
    for (int c = 0; c < 6 && !acked; c++) begin
      cyc();
      lat++;
      if (ram_we != 4'h0) wcount++;
      if (ack_o[1]) begin acount++; acked = 1'b1; end
    end
    req = 2'b00; we1 = 4'h0; a1 = 3'd0; d1 = 32'h0;
    repeat (4) begin
      cyc();
      if (ram_we != 4'h0) wcount++;
      if (ack_o != 2'b00) acount++;
    end
    chk("single_lat",    32'(lat),    32'd2);
    chk("single_writes", 32'(wcount), 32'd1);
    chk("single_acks",   32'(acount), 32'd1);
    chk("single_mem6",   mem[6],      32'h5A5A5A5A);
    $display("single: latency=%0d writes=%0d acks=%0d", lat, wcount, acount);

    // Reset during the RAM cycle of an access: grant clears at once, no ack, clean regrant.
    req = 2'b01; we0 = 4'hF; a0 = 3'd7; d0 = 32'h77777777;
    cyc();
    chk("mid_grant_t", 32'(grant_o), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_grant_rst", 32'(grant_o), 32'h0);
    chk("mid_we_rst",    32'(ram_we),  32'h0);
    cyc();
    chk("mid_ack_rst", 32'(ack_o), 32'h0);
    rst_n = 1'b1;
    cyc();
    chk("mid_regrant",  32'(grant_o),  32'h1);
    chk("mid_regr_we",  32'(ram_we),   32'hF);
    chk("mid_regr_adr", 32'(ram_addr), 32'h7);
    cyc();
    chk("mid_reack", 32'(ack_o), 32'h1);
    req = 2'b00;
    cyc();
    chk("mid_idle", 32'(grant_o | ack_o), 32'h0);
    chk("mid_mem7", mem[7], 32'h77777777);
    $display("reset-mid-access: regrant and ack seen, mem7=%h", mem[7]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
